onchip_mem_arbiter: RTL and testbench

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter_if.sv | 58 +++++
 rtl/onchip_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between two masters, the arbiter and a single-port RAM.
// The slave modport is the arbiter's view; master is the view of the surrounding system.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              clear_start;
  logic              clear_busy;

  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  logic              m0_waitrequest;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  logic              m1_waitrequest;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  clear_start,
    output clear_busy,
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_readdata, m0_readdatavalid, m0_waitrequest,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_readdata, m1_readdatavalid, m1_waitrequest,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    input  mem_readdata
  );

  modport master (
    output clear_start,
    input  clear_busy,
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_readdata, m0_readdatavalid, m0_waitrequest,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_readdata, m1_readdatavalid, m1_waitrequest,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM, with a
// zero-fill engine that sweeps the whole RAM on request or after reset.
module onchip_mem_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int NUMWORDS       = 37500,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  onchip_mem_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUMWORDS - 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;

  state_t            state_q;
  logic              last_grant_q;
  logic              rd_owner_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] clr_cnt_d;

  logic req0_s, req1_s, arb_s, clr_s;
  logic gnt0_s, gnt1_s, gnt_s, sel_s, sel_wr_s;

  assign clr_cnt_d = clr_cnt_q + ADDR_W'(1);

  // Grant decision; gated by reset_n so the bus is quiet while reset is held.
  always_comb begin
    req0_s = bus.m0_read | bus.m0_write;
    req1_s = bus.m1_read | bus.m1_write;
    arb_s  = reset_n & (state_q == ST_ARB);
    clr_s  = reset_n & (state_q == ST_CLEAR);
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (arb_s) begin
      if (req0_s & req1_s) begin
        gnt0_s = last_grant_q;
        gnt1_s = ~last_grant_q;
      end else begin
        gnt0_s = req0_s;
        gnt1_s = req1_s;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
    gnt_s    = gnt0_s | gnt1_s;
    sel_s    = gnt1_s;
    sel_wr_s = sel_s ? bus.m1_write : bus.m0_write;
  end

  // RAM-side mux: granted master in ARB, zero-fill sweep in CLEAR.
  always_comb begin
    bus.mem_address    = sel_s ? bus.m1_address    : bus.m0_address;
    bus.mem_byteenable = sel_s ? bus.m1_byteenable : bus.m0_byteenable;
    bus.mem_writedata  = sel_s ? bus.m1_writedata  : bus.m0_writedata;
    bus.mem_chipselect = gnt_s;
    bus.mem_write      = gnt_s & sel_wr_s;
    if (clr_s) begin
      bus.mem_address    = clr_cnt_q;
      bus.mem_byteenable = {BE_W{1'b1}};
      bus.mem_writedata  = {DATA_W{1'b0}};
      bus.mem_chipselect = 1'b1;
      bus.mem_write      = 1'b1;
    end else begin
      bus.mem_chipselect = gnt_s;
      bus.mem_write      = gnt_s & sel_wr_s;
    end
  end

  assign bus.m0_waitrequest   = ~gnt0_s;
  assign bus.m1_waitrequest   = ~gnt1_s;
  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;
  assign bus.m0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign bus.m1_readdatavalid = rd_pend_q & rd_owner_q;
  assign bus.clear_busy       = (state_q == ST_CLEAR);

  // Arbitration / clear FSM with read-return tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RST_STATE;
      clr_cnt_q    <= {ADDR_W{1'b0}};
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          rd_pend_q <= gnt_s & ~sel_wr_s;
          if (gnt_s) begin
            last_grant_q <= sel_s;
          end
          if (gnt_s & ~sel_wr_s) begin
            rd_owner_q <= sel_s;
          end
          if (bus.clear_start) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= {ADDR_W{1'b0}};
          end
        end
        ST_CLEAR: begin
          rd_pend_q <= 1'b0;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q   <= ST_ARB;
            clr_cnt_q <= {ADDR_W{1'b0}};
          end else begin
            clr_cnt_q <= clr_cnt_d;
          end
        end
        default: begin
          state_q   <= ST_ARB;
          rd_pend_q <= 1'b0;
          clr_cnt_q <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench: arbiter with an attached RAM model, plus a second instance
// built with zero-fill on reset.
module tb_onchip_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int NW     = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic reset_c;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ram [0:511];
  logic [31:0] rd_q;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_c ();

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUMWORDS(NW), .CLEAR_ON_RESET(0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUMWORDS(NW), .CLEAR_ON_RESET(1)) dut_c (
    .clk(clk), .reset_n(reset_c), .bus(bus_c));

  always #5 clk = ~clk;

  assign bus.mem_readdata   = rd_q;
  assign bus_c.mem_readdata = 32'h0000_0000;

  // RAM model: one-cycle read latency, byte-lane writes, preloaded while reset is low.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'hC0DE_0000 | 32'(i);
      ram[16]  <= 32'hDEAD_BEEF;
      ram[256] <= 32'hAAAA_AAAA;
      rd_q     <= 32'h0000_0000;
    end else if (bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address[8:0]][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end else begin
        rd_q <= ram[bus.mem_address[8:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_idle();
    bus.clear_start   = 1'b0;
    bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m0_address = 16'h0000;
    bus.m0_byteenable = 4'hF; bus.m0_writedata = 32'h0000_0000;
    bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_address = 16'h0000;
    bus.m1_byteenable = 4'hF; bus.m1_writedata = 32'h0000_0000;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    reset_c = 1'b0;
    m_idle();
    bus_c.clear_start = 1'b0;
    bus_c.m0_read = 1'b0; bus_c.m0_write = 1'b0; bus_c.m0_address = 16'h0000;
    bus_c.m0_byteenable = 4'hF; bus_c.m0_writedata = 32'h0000_0000;
    bus_c.m1_read = 1'b0; bus_c.m1_write = 1'b0; bus_c.m1_address = 16'h0000;
    bus_c.m1_byteenable = 4'hF; bus_c.m1_writedata = 32'h0000_0000;

    // Reset values, with requests present that must not leak through
    repeat (2) nxt();
    bus.m0_read = 1'b1; bus.m0_address = 16'h0010; bus.m1_write = 1'b1;
    smp();
    chk("rst_m0_wait", bus.m0_waitrequest, 32'd1);
    chk("rst_m1_wait", bus.m1_waitrequest, 32'd1);
    chk("rst_cs", bus.mem_chipselect, 32'd0);
    chk("rst_we", bus.mem_write, 32'd0);
    chk("rst_busy", bus.clear_busy, 32'd0);
    chk("rst_m0_rdv", bus.m0_readdatavalid, 32'd0);
    chk("rst_m1_rdv", bus.m1_readdatavalid, 32'd0);
    chk("c_rst_busy", bus_c.clear_busy, 32'd1);
    chk("c_rst_cs", bus_c.mem_chipselect, 32'd0);
    chk("c_rst_wait", bus_c.m0_waitrequest, 32'd1);
    m_idle();
    reset_n = 1'b1;

    // Single read by m0
    nxt(); bus.m0_read = 1'b1; bus.m0_address = 16'h0010;
    smp();
    chk("rd_m0_wait", bus.m0_waitrequest, 32'd0);
    chk("rd_m1_wait", bus.m1_waitrequest, 32'd1);
    chk("rd_cs", bus.mem_chipselect, 32'd1);
    chk("rd_addr", bus.mem_address, 32'h0010);
    chk("rd_we", bus.mem_write, 32'd0);
    nxt(); m_idle();
    smp();
    chk("rd_m0_rdv", bus.m0_readdatavalid, 32'd1);
    chk("rd_data", bus.m0_readdata, 32'hDEAD_BEEF);
    chk("rd_m1_rdv", bus.m1_readdatavalid, 32'd0);
    chk("idle_cs", bus.mem_chipselect, 32'd0);

    // Fresh reset so m0 wins the first tie
    reset_n = 1'b0; nxt(); smp(); reset_n = 1'b1;

    // Both masters reading continuously: m0, m1, m0, m1
    for (int c = 0; c < 5; c++) begin
      nxt();
      if (c == 0) begin
        bus.m0_read = 1'b1; bus.m0_address = 16'h0020;
        bus.m1_read = 1'b1; bus.m1_address = 16'h0030;
      end
      if (c == 4) m_idle();
      smp();
      chk("alt_m0_wait", bus.m0_waitrequest, (c < 4 && c % 2 == 0) ? 32'd0 : 32'd1);
      chk("alt_m1_wait", bus.m1_waitrequest, (c < 4 && c % 2 == 1) ? 32'd0 : 32'd1);
      chk("alt_m0_rdv", bus.m0_readdatavalid, (c == 1 || c == 3) ? 32'd1 : 32'd0);
      chk("alt_m1_rdv", bus.m1_readdatavalid, (c == 2 || c == 4) ? 32'd1 : 32'd0);
      if (c == 1 || c == 3) chk("alt_m0_data", bus.m0_readdata, 32'hC0DE_0020);
      if (c == 2 || c == 4) chk("alt_m1_data", bus.m1_readdata, 32'hC0DE_0030);
    end

    // Partial write by m1, then read back by m0
    nxt();
    bus.m1_write = 1'b1; bus.m1_address = 16'h0100;
    bus.m1_byteenable = 4'b0011; bus.m1_writedata = 32'h1234_5678;
    smp();
    chk("wr_m1_wait", bus.m1_waitrequest, 32'd0);
    chk("wr_we", bus.mem_write, 32'd1);
    chk("wr_addr", bus.mem_address, 32'h0100);
    chk("wr_be", bus.mem_byteenable, 32'h3);
    chk("wr_wdata", bus.mem_writedata, 32'h1234_5678);
    nxt(); m_idle(); bus.m0_read = 1'b1; bus.m0_address = 16'h0100;
    smp();
    chk("wr_no_rdv", bus.m1_readdatavalid, 32'd0);
    chk("rb_m0_wait", bus.m0_waitrequest, 32'd0);
    nxt(); m_idle();
    smp();
    chk("rb_rdv", bus.m0_readdatavalid, 32'd1);
    chk("rb_data", bus.m0_readdata, 32'hAAAA_5678);

    // Read and write together count as a write
    nxt();
    bus.m0_read = 1'b1; bus.m0_write = 1'b1; bus.m0_address = 16'h0040;
    bus.m0_writedata = 32'h0000_0055;
    smp();
    chk("rw_we", bus.mem_write, 32'd1);
    nxt(); m_idle();
    smp();
    chk("rw_no_rdv", bus.m0_readdatavalid, 32'd0);

    // Clear request alongside an m0 write
    nxt();
    bus.m0_write = 1'b1; bus.m0_address = 16'h0041; bus.m0_writedata = 32'h0000_0077;
    bus.clear_start = 1'b1;
    smp();
    chk("cs_m0_wait", bus.m0_waitrequest, 32'd0);
    chk("cs_we", bus.mem_write, 32'd1);
    chk("cs_addr", bus.mem_address, 32'h0041);
    chk("cs_busy", bus.clear_busy, 32'd0);
    for (int i = 0; i < NW; i++) begin
      nxt();
      if (i == 0) begin
        m_idle(); bus.m0_read = 1'b1; bus.m0_address = 16'h0010;
      end
      if (i == 3) bus.clear_start = 1'b1;
      if (i == 4) bus.clear_start = 1'b0;
      smp();
      chk("clr_busy", bus.clear_busy, 32'd1);
      chk("clr_addr", bus.mem_address, 32'(i));
      chk("clr_we", bus.mem_write, 32'd1);
      chk("clr_be", bus.mem_byteenable, 32'hF);
      chk("clr_wdata", bus.mem_writedata, 32'h0);
      chk("clr_m0_wait", bus.m0_waitrequest, 32'd1);
    end
    nxt(); smp();
    chk("post_busy", bus.clear_busy, 32'd0);
    chk("post_m0_wait", bus.m0_waitrequest, 32'd0);
    chk("post_addr", bus.mem_address, 32'h0010);
    chk("post_we", bus.mem_write, 32'd0);
    nxt(); bus.m0_address = 16'h0003;
    smp();
    chk("post_rdv", bus.m0_readdatavalid, 32'd1);
    chk("post_data", bus.m0_readdata, 32'hDEAD_BEEF);
    nxt(); m_idle();
    smp();
    chk("zero_rdv", bus.m0_readdatavalid, 32'd1);
    chk("zero_data", bus.m0_readdata, 32'h0);

    // Reset during the return cycle of a read
    nxt(); bus.m0_read = 1'b1; bus.m0_address = 16'h0010;
    smp();
    chk("ab_m0_wait", bus.m0_waitrequest, 32'd0);
    nxt(); m_idle();
    chk("ab_pre_rdv", bus.m0_readdatavalid, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("ab_rdv", bus.m0_readdatavalid, 32'd0);
    smp(); reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      nxt(); smp();
      chk("ab_post_rdv", bus.m0_readdatavalid, 32'd0);
    end

    // Zero-fill on reset, interrupted at address 5, restarting from 0
    reset_c = 1'b1;
    #1;
    chk("c_addr0", bus_c.mem_address, 32'h0);
    chk("c_busy", bus_c.clear_busy, 32'd1);
    chk("c_cs", bus_c.mem_chipselect, 32'd1);
    for (int i = 1; i < 6; i++) begin
      smp();
      chk("c_addr", bus_c.mem_address, 32'(i));
    end
    reset_c = 1'b0;
    #1;
    chk("c_mid_cs", bus_c.mem_chipselect, 32'd0);
    chk("c_mid_we", bus_c.mem_write, 32'd0);
    chk("c_mid_busy", bus_c.clear_busy, 32'd1);
    chk("c_mid_wait", bus_c.m0_waitrequest, 32'd1);
    smp(); reset_c = 1'b1;
    #1;
    chk("c_re_addr", bus_c.mem_address, 32'h0);
    chk("c_re_busy", bus_c.clear_busy, 32'd1);
    for (int i = 1; i < NW; i++) begin
      smp();
      chk("c_re_addr", bus_c.mem_address, 32'(i));
      chk("c_re_busy", bus_c.clear_busy, 32'd1);
    end
    smp();
    chk("c_done_busy", bus_c.clear_busy, 32'd0);
    chk("c_done_cs", bus_c.mem_chipselect, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
